mem_port_arbiter: RTL

Three-requester arbiter for the single-port 32-bit word memory shared by the multicycle RISC-V core.
- Port 0 is the host/program loader, port 1 is the core's instruction fetch, port 2 is the core's load/store unit.
- The block picks at most one requester per cycle (round-robin, with a bounded lock for loader bursts) and drives the memory command.
- It returns read data one cycle later to the port that issued the read.
- It replaces the core's separate private instruction and data arrays.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/rr_pick3.sv | 25 ++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's unified word memory and its port arbiter.
package riscv_mem_pkg;

    localparam int unsigned NUM_PORTS  = 3;
    localparam int unsigned PORT_LOAD  = 0;
    localparam int unsigned PORT_IF    = 1;
    localparam int unsigned PORT_LS    = 2;
    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 32;

    typedef logic [1:0] port_idx_t;

    // Round-robin successor over the three ports.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = riscv_mem_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = riscv_mem_pkg::MEM_DATA_W
);
    import riscv_mem_pkg::*;

    logic [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             lock;
    logic [NUM_PORTS-1:0]             we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]             gnt;
    logic [NUM_PORTS-1:0]             rvalid;
    logic [DATA_W-1:0]                rdata;

    logic                             mem_en;
    logic                             mem_we;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic [DATA_W-1:0]                mem_rdata;

    // Requesters plus the memory array.
    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    // The arbiter itself.
    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker: first requester at or after ptr wins.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win_oh,
    output logic [1:0] win_idx
);

    int unsigned j;

    // Scan from lowest priority to highest so the highest-priority hit is written last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        j       = 0;
        for (int i = 2; i >= 0; i--) begin
            j = (int'(ptr) + i) % 3;
            if (req[j]) begin
                win_oh  = 3'b001 << j;
                win_idx = 2'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates loader, fetch and load/store ports onto one single-port word memory.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned LOCK_MAX = 8
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    port_idx_t         ptr_q, ptr_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    port_idx_t         rd_owner_q, rd_owner_d;

    logic [2:0]        win_oh;
    port_idx_t         win_idx;
    logic              win_any;
    logic [7:0]        cnt_eff;
    logic [8:0]        cnt_inc;
    logic              hold;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    rr_pick3 u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        // A nonzero count only belongs to the port the pointer is parked on.
        cnt_eff    = (win_idx == ptr_q) ? lock_cnt_q : '0;
        cnt_inc    = {1'b0, cnt_eff} + 9'd1;
        hold       = bus.lock[win_idx] && (cnt_inc < 9'(LOCK_MAX));
        ptr_d      = ptr_q;
        lock_cnt_d = '0;
        if (win_any) begin
            if (hold) begin
                ptr_d      = win_idx;
                lock_cnt_d = cnt_inc[7:0];
            end else begin
                ptr_d = next_port(win_idx);
            end
        end
        rd_pend_d  = win_any && !bus.we[win_idx];
        rd_owner_d = win_any ? win_idx : rd_owner_q;
    end

    always_comb begin
        win_any       = rst_n && (|win_oh);
        cmd_addr      = bus.addr[win_idx];
        cmd_wdata     = bus.wdata[win_idx];
        bus.gnt       = rst_n ? win_oh : '0;
        bus.mem_en    = win_any;
        bus.mem_we    = win_any && bus.we[win_idx];
        bus.mem_addr  = cmd_addr;
        bus.mem_wdata = cmd_wdata;
        bus.rdata     = bus.mem_rdata;
        bus.rvalid    = '0;
        if (rst_n && rd_pend_q) begin
            bus.rvalid[rd_owner_q] = 1'b1;
        end
    end

endmodule
